// File: rtl/guitar_pkg.sv
// guitar_pkg: shared types, widths and score helpers for the guitar game control path.
package guitar_pkg;
    typedef enum logic [1:0] {IDLE, PLAY, DONE} seq_state_t;
    localparam int NOTE_W = 5;
    localparam int POS_W = 7;
    localparam logic [6:0] SCORE_MAX = 7'd127;
    function automatic logic [6:0] sat_inc(input logic [6:0] v);
        return v == SCORE_MAX ? v : v + 7'd1;
    endfunction
endpackage

// File: rtl/step_timer.sv
// step_timer: free-running step counter with a registered pulse on the last cycle of each step.
module step_timer #(
    parameter int STEP_CYCLES = 25_000_000,
    parameter int CNT_W = $clog2(STEP_CYCLES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] step_cnt,
    output logic             tick
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);
    // tick is precomputed one count early so it is a flop yet aligned with step_cnt == LAST
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            step_cnt <= '0;
            tick <= 1'b0;
        end else if (en) begin
            step_cnt <= step_cnt == LAST ? '0 : step_cnt + 1'b1;
            tick <= step_cnt == LAST - 1'b1;
        end else begin
            tick <= 1'b0;
        end
    end
endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: steps the song position at a fixed tempo and scores button edges against notes.
module song_sequencer
    import guitar_pkg::*;
#(
    parameter int STEP_CYCLES = 25_000_000,
    parameter int SONG_LEN = 100,
    parameter int POS_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              button_in,
    input  logic [4:0]        songD,
    output logic [POS_W-1:0]  songDataPos,
    output logic              playing,
    output logic              done,
    output logic              step_tick,
    output logic [6:0]        hit_count,
    output logic [6:0]        miss_count
);
    localparam int CNT_W = $clog2(STEP_CYCLES);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(SONG_LEN - 1);
    seq_state_t state;
    logic [CNT_W-1:0] step_cnt;
    logic btn_q, judged, note_ok, hit_now, miss_now;
    step_timer #(.STEP_CYCLES(STEP_CYCLES), .CNT_W(CNT_W)) u_timer (
        .clk(clk),
        .reset(reset),
        .en(state == PLAY),
        .clr(state != PLAY),
        .step_cnt(step_cnt),
        .tick(step_tick)
    );
    // songD lags a position change by a cycle, so the first two counts of a step are blanked
    assign note_ok = step_cnt >= CNT_W'(2) && songD != '0 && !judged;
    assign hit_now = note_ok && button_in && !btn_q;
    assign miss_now = note_ok && !hit_now;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            songDataPos <= '0;
            playing <= 1'b0;
            done <= 1'b0;
            hit_count <= '0;
            miss_count <= '0;
            btn_q <= 1'b0;
            judged <= 1'b0;
        end else begin
            btn_q <= button_in;
            if (state != PLAY) begin
                if (start) begin
                    state <= PLAY;
                    playing <= 1'b1;
                    done <= 1'b0;
                    songDataPos <= '0;
                    hit_count <= '0;
                    miss_count <= '0;
                    judged <= 1'b0;
                end
            end else begin
                if (hit_now)
                    hit_count <= sat_inc(hit_count);
                if (step_tick) begin
                    judged <= 1'b0;
                    if (miss_now)
                        miss_count <= sat_inc(miss_count);
                    if (songDataPos < LAST_POS) begin
                        songDataPos <= songDataPos + 1'b1;
                    end else begin
                        state <= DONE;
                        playing <= 1'b0;
                        done <= 1'b1;
                    end
                end else if (hit_now) begin
                    judged <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: directed checks of tempo, judging, saturation and reset for song_sequencer.
module tb_song_sequencer;
    logic clk = 1'b0;
    logic reset, start, button_in, start2;
    logic no_button = 1'b0;
    logic [4:0] song_d, song_d2;
    logic [6:0] pos, pos2, hit, miss, hit2, miss2;
    logic playing, done, tick, playing2, done2, tick2;
    int checks = 0;
    int errors = 0;
    int ticks_seen = 0;
    logic [4:0] rom [4] = '{5'd1, 5'd0, 5'd4, 5'd16};

    always #5 clk = ~clk;

    // datapath model: note for the current position arrives one cycle after the position
    always @(posedge clk) begin
        song_d <= rom[pos[1:0]];
        song_d2 <= 5'd3;
    end

    song_sequencer #(.STEP_CYCLES(8), .SONG_LEN(4), .POS_W(7)) dut (
        .clk(clk), .reset(reset), .start(start), .button_in(button_in), .songD(song_d),
        .songDataPos(pos), .playing(playing), .done(done), .step_tick(tick),
        .hit_count(hit), .miss_count(miss)
    );

    song_sequencer #(.STEP_CYCLES(8), .SONG_LEN(128), .POS_W(7)) dut_sat (
        .clk(clk), .reset(reset), .start(start2), .button_in(no_button), .songD(song_d2),
        .songDataPos(pos2), .playing(playing2), .done(done2), .step_tick(tick2),
        .hit_count(hit2), .miss_count(miss2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (tick) ticks_seen++;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; button_in = 1'b0; start2 = 1'b0;
        cyc(3);
        reset = 1'b0;
        ticks_seen = 0;
        cyc(20);
        chk("idle_pos", 32'(pos), 0);
        chk("idle_playing", 32'(playing), 0);
        chk("idle_done", 32'(done), 0);
        chk("idle_hit", 32'(hit), 0);
        chk("idle_miss", 32'(miss), 0);
        chk("idle_ticks", 32'(ticks_seen), 0);

        // full play, no presses
        start = 1'b1; cyc(1); start = 1'b0;
        chk("play_playing", 32'(playing), 1);
        chk("play_pos0", 32'(pos), 0);
        ticks_seen = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(i == 0 ? 7 : 8);
            chk("play_tick", 32'(tick), 1);
            chk("play_pos", 32'(pos), 32'(i));
        end
        chk("play_tick_count", 32'(ticks_seen), 4);
        cyc(1);
        chk("play_done", 32'(done), 1);
        chk("play_not_playing", 32'(playing), 0);
        chk("play_miss", 32'(miss), 3);
        chk("play_hit", 32'(hit), 0);
        chk("play_done_pos", 32'(pos), 3);

        // hits and edge handling, restarted from DONE
        start = 1'b1; cyc(1); start = 1'b0;
        chk("restart_hit", 32'(hit), 0);
        chk("restart_miss", 32'(miss), 0);
        chk("restart_pos", 32'(pos), 0);
        chk("restart_playing", 32'(playing), 1);
        chk("restart_done", 32'(done), 0);
        cyc(3);
        button_in = 1'b1; cyc(1); button_in = 1'b0;
        chk("hit_first", 32'(hit), 1);
        cyc(1);
        button_in = 1'b1; cyc(1); button_in = 1'b0;
        chk("hit_second_edge", 32'(hit), 1);
        cyc(2);
        chk("step0_no_miss", 32'(miss), 0);
        cyc(3);
        button_in = 1'b1; cyc(1); button_in = 1'b0;
        chk("hit_rest", 32'(hit), 1);
        cyc(7);
        button_in = 1'b1; cyc(1);
        chk("hit_step2", 32'(hit), 2);
        cyc(4);
        chk("held_pos3", 32'(pos), 3);
        chk("held_miss", 32'(miss), 0);
        cyc(7);
        chk("held_tick", 32'(tick), 1);
        button_in = 1'b0;
        cyc(1);
        chk("held_done", 32'(done), 1);
        chk("held_hit", 32'(hit), 2);
        chk("held_miss_final", 32'(miss), 1);

        // settle blank and tick-cycle hit
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(1);
        button_in = 1'b1; cyc(1);
        chk("settle_ignored", 32'(hit), 0);
        button_in = 1'b0;
        cyc(6);
        chk("settle_miss", 32'(miss), 1);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("start_ignored_pos", 32'(pos), 1);
        chk("start_ignored_miss", 32'(miss), 1);
        cyc(7);
        chk("rest_no_miss", 32'(miss), 1);
        chk("rest_pos2", 32'(pos), 2);
        cyc(7);
        chk("edge_tick", 32'(tick), 1);
        button_in = 1'b1; cyc(1); button_in = 1'b0;
        chk("tick_hit", 32'(hit), 1);
        chk("tick_no_miss", 32'(miss), 1);
        chk("tick_pos3", 32'(pos), 3);
        cyc(8);
        chk("boundary_done", 32'(done), 1);
        chk("boundary_miss", 32'(miss), 2);

        // reset mid-song
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(16);
        chk("mid_pos2", 32'(pos), 2);
        chk("mid_miss", 32'(miss), 1);
        reset = 1'b1; cyc(1); reset = 1'b0;
        chk("rst_pos", 32'(pos), 0);
        chk("rst_playing", 32'(playing), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_hit", 32'(hit), 0);
        chk("rst_miss", 32'(miss), 0);
        cyc(10);
        chk("rst_idle_pos", 32'(pos), 0);
        chk("rst_idle_playing", 32'(playing), 0);

        // miss counter saturation over a 128-step song
        start2 = 1'b1; cyc(1); start2 = 1'b0;
        begin
            int k = 0;
            while (!done2 && k < 2000) begin
                cyc(1);
                k++;
            end
        end
        chk("sat_done", 32'(done2), 1);
        chk("sat_miss", 32'(miss2), 127);
        chk("sat_hit", 32'(hit2), 0);
        chk("sat_pos", 32'(pos2), 127);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
